// File: rtl/bw_iodll_loop_ctl.sv
// bw_iodll_loop_ctl
//   Loop controller for the DDR DLL delay lines. Phase-detector up/down votes
//   are integrated in a small signed filter; each time the filter reaches
//   +/-FILT_TH a code step is issued. The internal code is published on lpf_out
//   only during an upd_req/upd_ack handshake, so slave lines never see a change
//   mid-burst. Lock is declared after a direction reversal and dropped after a
//   run of same-direction steps.
//
// Ports
//   clk          core clock, rising edge
//   reset        synchronous active-high reset
//   enable       loop enable; low freezes the code (state drops to IDLE)
//   pd_up/pd_dn  phase detector votes, sampled every cycle
//   ovr_en       software override; code follows ovr_code
//   ovr_code     override code
//   upd_ack      slave lines idle; lpf_out may change this cycle
//   lpf_out      registered delay code to slave lines
//   upd_req      registered: internal code differs from lpf_out
//   locked       registered: state is TRACK
//   code_min_err sticky: down-step requested at code 0
//   code_max_err sticky: up-step requested at max code
module bw_iodll_loop_ctl #(
    parameter int CODE_W    = 5,
    parameter int INIT_CODE = 16,
    parameter int FILT_TH   = 8,
    parameter int FILT_W    = 5,
    parameter int TRK_LOSS  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pd_up,
    input  logic              pd_dn,
    input  logic              ovr_en,
    input  logic [CODE_W-1:0] ovr_code,
    input  logic              upd_ack,
    output logic [CODE_W-1:0] lpf_out,
    output logic              upd_req,
    output logic              locked,
    output logic              code_min_err,
    output logic              code_max_err
);
    typedef enum logic [1:0] {IDLE, ACQ, TRACK, OVR} state_t;

    localparam int CNT_W = $clog2(TRK_LOSS + 1);
    localparam logic signed [FILT_W-1:0] ONE  = FILT_W'(1);
    localparam logic signed [FILT_W-1:0] TH   = FILT_W'(FILT_TH);
    localparam logic signed [FILT_W-1:0] NTH  = -TH;
    localparam logic [CODE_W-1:0]        INIT = CODE_W'(INIT_CODE);
    localparam logic [CNT_W-1:0]         LOSS_M1 = CNT_W'(TRK_LOSS - 1);
    localparam logic [CNT_W-1:0]         CNT_MAX = '1;

    state_t                    state, state_nxt;
    logic signed [FILT_W-1:0]  acc, acc_nxt, acc_sum;
    logic [CODE_W-1:0]         code, code_nxt, lpf_nxt;
    logic                      step_up_q, step_dn_q, hit_up, hit_dn;
    logic                      hist_vld, hist_vld_nxt, hist_dir, hist_dir_nxt;
    logic [CNT_W-1:0]          run_cnt, run_cnt_nxt;
    logic                      run, step_vld, step_dir, same_dir, clr_hist;
    logic                      min_set, max_set;

    // Filter and step application only while actively tracking the loop.
    assign run      = (state == ACQ || state == TRACK) && !ovr_en && enable;
    // Threshold hits are registered and applied to the code one cycle later.
    assign step_vld = run && (step_up_q || step_dn_q);
    assign step_dir = step_up_q;
    assign same_dir = hist_vld && (hist_dir == step_dir);

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ovr_en)      state_nxt = OVR;
                else if (enable) state_nxt = ACQ;
            end
            OVR: begin
                if (!ovr_en) state_nxt = enable ? ACQ : IDLE;
            end
            default: begin // ACQ, TRACK
                if (ovr_en)       state_nxt = OVR;
                else if (!enable) state_nxt = IDLE;
                else if (step_vld) begin
                    if (state == ACQ && hist_vld && !same_dir)
                        state_nxt = TRACK;
                    else if (state == TRACK && same_dir && run_cnt >= LOSS_M1)
                        state_nxt = ACQ;
                end
            end
        endcase
    end

    // Entering any state but TRACK restarts filter and lock history.
    assign clr_hist = (state_nxt != state) && (state_nxt != TRACK);

    // Filter accumulator; the threshold value is never stored.
    always_comb begin
        acc_sum = acc;
        acc_nxt = acc;
        hit_up  = 1'b0;
        hit_dn  = 1'b0;
        if (run) begin
            if (pd_up && !pd_dn)      acc_sum = acc + ONE;
            else if (pd_dn && !pd_up) acc_sum = acc - ONE;
            if (acc_sum == TH) begin
                hit_up  = 1'b1;
                acc_nxt = '0;
            end else if (acc_sum == NTH) begin
                hit_dn  = 1'b1;
                acc_nxt = '0;
            end else begin
                acc_nxt = acc_sum;
            end
        end
        if (clr_hist || state == IDLE || state == OVR) acc_nxt = '0;
    end

    // Step history; saturated steps still count.
    always_comb begin
        hist_vld_nxt = hist_vld;
        hist_dir_nxt = hist_dir;
        run_cnt_nxt  = run_cnt;
        if (step_vld) begin
            if (same_dir) begin
                if (run_cnt != CNT_MAX) run_cnt_nxt = run_cnt + 1'b1;
            end else begin
                run_cnt_nxt = CNT_W'(1);
            end
            hist_vld_nxt = 1'b1;
            hist_dir_nxt = step_dir;
        end
        if (clr_hist) begin
            hist_vld_nxt = 1'b0;
            hist_dir_nxt = 1'b0;
            run_cnt_nxt  = '0;
        end
    end

    // Code update and handshake
    always_comb begin
        code_nxt = code;
        min_set  = 1'b0;
        max_set  = 1'b0;
        if (ovr_en) begin
            code_nxt = ovr_code;
        end else if (step_vld) begin
            if (step_dir) begin
                if (code == '1) max_set  = 1'b1;
                else            code_nxt = code + 1'b1;
            end else begin
                if (code == '0) min_set  = 1'b1;
                else            code_nxt = code - 1'b1;
            end
        end
        // lpf_out takes the current code only on handshake, so pending
        // changes coalesce into one transfer of the latest value.
        lpf_nxt = (upd_req && upd_ack) ? code : lpf_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            code         <= INIT;
            lpf_out      <= INIT;
            upd_req      <= 1'b0;
            locked       <= 1'b0;
            code_min_err <= 1'b0;
            code_max_err <= 1'b0;
            step_up_q    <= 1'b0;
            step_dn_q    <= 1'b0;
            hist_vld     <= 1'b0;
            hist_dir     <= 1'b0;
            run_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            acc          <= acc_nxt;
            code         <= code_nxt;
            lpf_out      <= lpf_nxt;
            upd_req      <= (code_nxt != lpf_nxt);
            locked       <= (state_nxt == TRACK);
            code_min_err <= code_min_err | min_set;
            code_max_err <= code_max_err | max_set;
            step_up_q    <= hit_up;
            step_dn_q    <= hit_dn;
            hist_vld     <= hist_vld_nxt;
            hist_dir     <= hist_dir_nxt;
            run_cnt      <= run_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_bw_iodll_loop_ctl.sv
// Directed bench for bw_iodll_loop_ctl: a table of multi-cycle input records
// with expected outputs after the last cycle, then hand sequences for filter
// cancellation, saturation, override and mid-operation reset.
module tb_bw_iodll_loop_ctl;
    logic       clk = 1'b0;
    logic       reset, enable, pd_up, pd_dn, ovr_en, upd_ack;
    logic [4:0] ovr_code;
    logic [4:0] lpf_out;
    logic       upd_req, locked, code_min_err, code_max_err;

    int total = 0;
    int bad   = 0;

    bw_iodll_loop_ctl dut (
        .clk(clk), .reset(reset), .enable(enable), .pd_up(pd_up), .pd_dn(pd_dn),
        .ovr_en(ovr_en), .ovr_code(ovr_code), .upd_ack(upd_ack),
        .lpf_out(lpf_out), .upd_req(upd_req), .locked(locked),
        .code_min_err(code_min_err), .code_max_err(code_max_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       rst, en, up, dn, ovr;
        logic [4:0] oc;
        logic       ack;
        logic [4:0] e_lpf;
        logic       e_req, e_lock, e_min, e_max;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic d,
                         input logic o, input logic [4:0] c, input logic a);
        reset = r; enable = e; pd_up = u; pd_dn = d; ovr_en = o; ovr_code = c; upd_ack = a;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string nm, input int lpf, input int req, input int lck,
                           input int mn, input int mx);
        chk({nm, ".lpf"},  int'(lpf_out),      lpf);
        chk({nm, ".req"},  int'(upd_req),      req);
        chk({nm, ".lock"}, int'(locked),       lck);
        chk({nm, ".min"},  int'(code_min_err), mn);
        chk({nm, ".max"},  int'(code_max_err), mx);
    endtask

    initial begin
        bit saw_req;
        //         n  rst en up dn ovr oc ack  lpf req lck mn mx
        tbl[0]  = '{3,  1, 1, 1, 0, 0, 0, 0,   16, 0, 0, 0, 0}; // reset w/ votes
        tbl[1]  = '{9,  0, 1, 1, 0, 0, 0, 0,   16, 0, 0, 0, 0}; // IDLE + 8 votes
        tbl[2]  = '{1,  0, 1, 0, 0, 0, 0, 0,   16, 1, 0, 0, 0}; // step lands
        tbl[3]  = '{1,  0, 1, 0, 0, 0, 0, 1,   17, 0, 0, 0, 0}; // handshake
        tbl[4]  = '{8,  0, 1, 0, 1, 0, 0, 0,   17, 0, 0, 0, 0}; // 8 down votes
        tbl[5]  = '{1,  0, 1, 0, 0, 0, 0, 0,   17, 1, 1, 0, 0}; // reversal -> lock
        tbl[6]  = '{1,  0, 1, 0, 0, 0, 0, 1,   16, 0, 1, 0, 0};
        tbl[7]  = '{24, 0, 1, 1, 0, 0, 0, 0,   16, 1, 1, 0, 0}; // 2 of 3 ups, no ack
        tbl[8]  = '{1,  0, 1, 0, 0, 0, 0, 0,   16, 1, 0, 0, 0}; // 3rd up -> ACQ
        tbl[9]  = '{1,  0, 1, 0, 0, 0, 0, 1,   19, 0, 0, 0, 0}; // coalesced jump
        tbl[10] = '{10, 0, 1, 1, 1, 0, 0, 1,   19, 0, 0, 0, 0}; // both high: hold

        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].dn, tbl[i].ovr, tbl[i].oc, tbl[i].ack);
            cycles(tbl[i].n);
            chk_all($sformatf("row%0d", i), tbl[i].e_lpf, tbl[i].e_req, tbl[i].e_lock,
                    tbl[i].e_min, tbl[i].e_max);
        end

        // Alternating votes cancel: no step ever requested.
        saw_req = 0;
        for (int k = 0; k < 100; k++) begin
            drive(0, 1, k[0] == 1'b0, k[0] == 1'b1, 0, 0, 0);
            cycles(1);
            if (upd_req) saw_req = 1;
        end
        chk("cancel.req_seen", int'(saw_req), 0);
        chk_all("cancel", 19, 0, 0, 0, 0);

        // Saturate high then low; flags sticky.
        drive(0, 1, 1, 0, 0, 0, 1);
        cycles(200);
        chk_all("sat_hi", 31, 0, 0, 0, 1);
        drive(0, 1, 0, 1, 0, 0, 1);
        cycles(300);
        chk_all("sat_lo", 0, 0, 0, 1, 1);

        // Override: code follows ovr_code, votes ignored.
        drive(0, 1, 1, 0, 1, 5'd5, 1);
        cycles(3);
        chk_all("ovr5", 5, 0, 0, 1, 1);
        cycles(10);
        chk_all("ovr_hold", 5, 0, 0, 1, 1);
        drive(0, 1, 1, 0, 1, 5'd9, 0);
        cycles(1);
        chk_all("ovr9_req", 5, 1, 0, 1, 1);
        drive(0, 1, 1, 0, 1, 5'd9, 1);
        cycles(1);
        chk_all("ovr9_ack", 9, 0, 0, 1, 1);

        // Back to ACQ from a cleared filter: first step after 1 + 8 cycles.
        drive(0, 1, 1, 0, 0, 5'd9, 0);
        cycles(9);
        chk_all("acq_pre", 9, 0, 0, 1, 1);
        cycles(1);
        chk_all("acq_step", 9, 1, 0, 1, 1);

        // Reset mid-ACQ with a pending request.
        drive(1, 1, 1, 0, 0, 0, 0);
        cycles(1);
        chk_all("mid_reset", 16, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
